// File: rtl/pll_supervisor.sv
// pll_supervisor
//   Sequences an ECP5 EHXPLLL through reset and lock, then releases a set of
//   downstream reset channels one after another. Lock is re-checked for the
//   whole time the block runs. If lock is lost or a relock is requested, every
//   channel is pulled back into reset and the PLL is pulsed again.
//
// Ports
//   clkin         reference clock. This is the only clock, and all flops use its rising edge.
//   resetn        synchronous active-low reset
//   pll_locked    LOCK from the PLL. It is asynchronous, so it is synchronised here.
//   force_relock  single-cycle request to re-reset the PLL
//   pll_rst       PLL RST pin, active-high
//   ch_rstn       per-channel reset, active-low, released in staggered order
//   ready         high while every channel is released and the PLL is locked
//   state         0=PLL_RESET 1=WAIT_LOCK 2=STABLE 3=RELEASE 4=RUN
//   relock_count  lock losses seen after release started (saturating)
//   timeout_count lock-wait timeouts (saturating)
module pll_supervisor #(
   parameter int NUM_CH              = 3,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 250000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES      = 8,
   parameter int CNT_W               = 8
) (
   input  logic              clkin,
   input  logic              resetn,
   input  logic              pll_locked,
   input  logic              force_relock,
   output logic              pll_rst,
   output logic [NUM_CH-1:0] ch_rstn,
   output logic              ready,
   output logic [2:0]        state,
   output logic [CNT_W-1:0]  relock_count,
   output logic [CNT_W-1:0]  timeout_count
);

   localparam logic [2:0] S_PLL_RESET = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;

   // A single phase timer is shared by every state. Size it for the longest phase.
   localparam int REL_LAST = (NUM_CH - 1) * STAGGER_CYCLES;
   localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_B    = (LOCK_STABLE_CYCLES > REL_LAST) ? LOCK_STABLE_CYCLES : REL_LAST;
   localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW       = $clog2(CNT_MAX + 1);

   logic              sync1_q, sync1_d;
   logic              lock_s_q, lock_s_d;
   logic [2:0]        state_q, state_d;
   logic [TW-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]  relock_q, relock_d;
   logic [CNT_W-1:0]  timeout_q, timeout_d;
   logic              pll_rst_q, pll_rst_d;
   logic [NUM_CH-1:0] ch_rstn_q, ch_rstn_d;
   logic              ready_q, ready_d;
   logic              lock_lost;

   always_comb begin
      sync1_d   = pll_locked;
      lock_s_d  = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      relock_d  = relock_q;
      timeout_d = timeout_q;

      // Lock loss is checked before force_relock. When both happen in the same
      // cycle, there is one transition and the loss is still counted.
      lock_lost = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s_q;

      if (lock_lost) begin
         state_d  = S_PLL_RESET;
         relock_d = (&relock_q) ? relock_q : relock_q + 1'b1;
      end else if (force_relock && (state_q != S_PLL_RESET)) begin
         state_d = S_PLL_RESET;
      end else begin
         case (state_q)
            S_PLL_RESET: if (cnt_q == TW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
               if (lock_s_q) begin
                  state_d = S_STABLE;
               end else if (cnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  state_d   = S_PLL_RESET;
                  timeout_d = (&timeout_q) ? timeout_q : timeout_q + 1'b1;
               end
            end
            S_STABLE: begin
               if (!lock_s_q)                                   state_d = S_WAIT_LOCK;
               else if (cnt_q == TW'(LOCK_STABLE_CYCLES - 1))   state_d = S_RELEASE;
            end
            S_RELEASE: if (cnt_q == TW'(REL_LAST)) state_d = S_RUN;
            S_RUN:     cnt_d = cnt_q;   // no timing in RUN; hold to avoid wrap
            default:   state_d = S_PLL_RESET;
         endcase
      end

      // Every state entry restarts the phase timer at 0.
      if (state_d != state_q) cnt_d = '0;

      // Outputs are registered from the next state. The timer value therefore
      // lines up with the cycle in which each output becomes visible.
      pll_rst_d = (state_d == S_PLL_RESET);
      ready_d   = (state_d == S_RUN);
      for (int k = 0; k < NUM_CH; k++) begin
         ch_rstn_d[k] = (state_d == S_RUN) ||
                        ((state_d == S_RELEASE) && (cnt_d >= TW'(k * STAGGER_CYCLES)));
      end
   end

   always_ff @(posedge clkin) begin
      if (!resetn) begin
         sync1_q   <= 1'b0;
         lock_s_q  <= 1'b0;
         state_q   <= S_PLL_RESET;
         cnt_q     <= '0;
         relock_q  <= '0;
         timeout_q <= '0;
         pll_rst_q <= 1'b1;
         ch_rstn_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         lock_s_q  <= lock_s_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         relock_q  <= relock_d;
         timeout_q <= timeout_d;
         pll_rst_q <= pll_rst_d;
         ch_rstn_q <= ch_rstn_d;
         ready_q   <= ready_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign ch_rstn       = ch_rstn_q;
   assign ready         = ready_q;
   assign state         = state_q;
   assign relock_count  = relock_q;
   assign timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Testbench for pll_supervisor.
// The first part is a set of directed scenarios. Each one checks absolute cycle
// numbers. After that comes a randomised run. A behavioural reference model is
// compared with every DUT output on every cycle throughout.
module tb_pll_supervisor;
   localparam int N = 3, PRC = 4, TO = 20, LSC = 10, S = 8, CW = 8, SATV = 255;

   logic clkin = 1'b0, resetn = 1'b0, pll_locked = 1'b0, force_relock = 1'b0;
   logic pll_rst, ready;
   logic [N-1:0] ch_rstn;
   logic [2:0] state;
   logic [CW-1:0] relock_count, timeout_count;

   int checks = 0, failures = 0, cyc = 0;

   // Reference model: the current phase, the number of cycles spent in it,
   // a two-deep lock delay line, and the event totals.
   int m_ph = 0, m_el = 0, m_rel = 0, m_to = 0;
   bit m_s1 = 1'b0, m_s2 = 1'b0, mchk = 1'b0;

   always #20 clkin = ~clkin;

   pll_supervisor #(.NUM_CH(N), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(TO),
                    .LOCK_STABLE_CYCLES(LSC), .STAGGER_CYCLES(S), .CNT_W(CW)) dut (
      .clkin(clkin), .resetn(resetn), .pll_locked(pll_locked), .force_relock(force_relock),
      .pll_rst(pll_rst), .ch_rstn(ch_rstn), .ready(ready), .state(state),
      .relock_count(relock_count), .timeout_count(timeout_count));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic int sat(input int v);
      return (v > SATV) ? SATV : v;
   endfunction

   function automatic logic [N-1:0] m_ch();
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) r[k] = (m_ph == 4) || (m_ph == 3 && m_el >= k * S);
      return r;
   endfunction

   // Advance the model by one clock edge, using the inputs present at that edge.
   task automatic model_step();
      bit ls;
      int nph;
      ls = m_s2;
      if (!resetn) begin
         m_ph = 0; m_el = 0; m_rel = 0; m_to = 0; m_s1 = 0; m_s2 = 0;
         return;
      end
      m_s2 = m_s1;
      m_s1 = pll_locked;
      nph = m_ph;
      if ((m_ph == 3 || m_ph == 4) && !ls) begin
         nph = 0; m_rel = sat(m_rel + 1);
      end else if (m_ph != 0 && force_relock) begin
         nph = 0;
      end else begin
         case (m_ph)
            0: if (m_el + 1 == PRC) nph = 1;
            1: if (ls) nph = 2; else if (m_el + 1 == TO) begin nph = 0; m_to = sat(m_to + 1); end
            2: if (!ls) nph = 1; else if (m_el + 1 == LSC) nph = 3;
            3: if (m_el == (N - 1) * S) nph = 4;
            default: nph = m_ph;
         endcase
      end
      m_el = (nph != m_ph) ? 0 : m_el + 1;
      m_ph = nph;
   endtask

   task automatic tick();
      @(posedge clkin);
      model_step();
      #1;
      cyc++;
      if (mchk) begin
         chk("m_state",   32'(state),         32'(m_ph));
         chk("m_pll_rst", 32'(pll_rst),       32'(m_ph == 0));
         chk("m_ch_rstn", 32'(ch_rstn),       32'(m_ch()));
         chk("m_ready",   32'(ready),         32'(m_ph == 4));
         chk("m_relock",  32'(relock_count),  32'(m_rel));
         chk("m_timeout", 32'(timeout_count), 32'(m_to));
      end
   endtask

   // Two reset edges. After the task, resetn is high and cyc=0 is the first PLL_RESET cycle.
   task automatic do_reset();
      resetn = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
      tick(); tick();
      mchk = 1'b1;
      resetn = 1'b1;
      cyc = 0;
   endtask

   initial begin
      int f_pll, r_rdy, r_any;
      int r_ch[N];
      int sseq[$];
      int rises[$];
      bit prev, rdy_seen;
      int n;

      // ---- normal start ----
      do_reset();
      chk("rst_state", 32'(state), 0);
      chk("rst_pll_rst", 32'(pll_rst), 1);
      chk("rst_ch_rstn", 32'(ch_rstn), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_relock", 32'(relock_count), 0);
      chk("rst_timeout", 32'(timeout_count), 0);
      f_pll = -1; r_rdy = -1;
      for (int k = 0; k < N; k++) r_ch[k] = -1;
      while (cyc <= 45) begin
         if (f_pll < 0 && !pll_rst) f_pll = cyc;
         for (int k = 0; k < N; k++) if (r_ch[k] < 0 && ch_rstn[k]) r_ch[k] = cyc;
         if (r_rdy < 0 && ready) r_rdy = cyc;
         if (sseq.size() == 0 || int'(state) != sseq[sseq.size()-1]) sseq.push_back(int'(state));
         if (cyc == 6) pll_locked = 1'b1;
         tick();
      end
      chk("start_pll_rst_fall", f_pll, 4);
      chk("start_ch0_rise", r_ch[0], 19);
      chk("start_ch1_rise", r_ch[1], 27);
      chk("start_ch2_rise", r_ch[2], 35);
      chk("start_ready_rise", r_rdy, 36);
      chk("start_state_seq_len", sseq.size(), 5);
      for (int i = 0; i < sseq.size() && i < 5; i++) chk("start_state_seq", sseq[i], i);

      // ---- lock timeout ----
      do_reset();
      prev = 1'b1; rdy_seen = 1'b0;
      while (cyc <= 72) begin
         if (pll_rst && !prev) rises.push_back(cyc);
         prev = pll_rst;
         if (ready) rdy_seen = 1'b1;
         if (cyc == 71) chk("to_count_2", 32'(timeout_count), 2);
         if (cyc == 72) chk("to_count_3", 32'(timeout_count), 3);
         tick();
      end
      chk("to_pulses", rises.size(), 3);
      for (int i = 0; i < rises.size() && i < 3; i++) chk("to_pulse_cycle", rises[i], 24 * (i + 1));
      chk("to_ready_never", 32'(rdy_seen), 0);

      // ---- lock glitch in STABLE ----
      do_reset();
      pll_locked = 1'b1;
      r_any = -1;
      while (cyc <= 30) begin
         if (r_any < 0 && ch_rstn != '0) r_any = cyc;
         if (cyc == 10) chk("gl_state_stable", 32'(state), 2);
         if (cyc == 11) chk("gl_state_wait", 32'(state), 1);
         if (cyc == 21) chk("gl_state_still_stable", 32'(state), 2);
         if (cyc == 21) chk("gl_relock", 32'(relock_count), 0);
         if (cyc == 8) pll_locked = 1'b0;
         if (cyc == 9) pll_locked = 1'b1;
         tick();
      end
      chk("gl_release_cycle", r_any, 22);

      // ---- lock loss in RUN ----
      do_reset();
      r_rdy = -1;
      while (cyc <= 80) begin
         if (cyc == 42) chk("ll_ready_before", 32'(ready), 1);
         if (cyc == 43) begin
            chk("ll_ch_rstn", 32'(ch_rstn), 0);
            chk("ll_ready", 32'(ready), 0);
            chk("ll_state", 32'(state), 0);
            chk("ll_relock", 32'(relock_count), 1);
         end
         if (cyc > 43 && r_rdy < 0 && ready) r_rdy = cyc;
         if (cyc == 6) pll_locked = 1'b1;
         if (cyc == 40) pll_locked = 1'b0;
         if (cyc == 43) pll_locked = 1'b1;
         tick();
      end
      chk("ll_ready_again", r_rdy, 75);
      chk("ll_relock_after", 32'(relock_count), 1);

      // ---- force + lock loss together, force during PLL_RESET, force in RUN ----
      do_reset();
      while (cyc <= 82) begin
         if (cyc == 43) begin
            chk("fr_state", 32'(state), 0);
            chk("fr_relock", 32'(relock_count), 1);
         end
         if (cyc == 46) chk("fr_pulse_held", 32'(pll_rst), 1);
         if (cyc == 47) begin
            chk("fr_pulse_end", 32'(pll_rst), 0);
            chk("fr_state_wait", 32'(state), 1);
         end
         if (cyc == 81) begin
            chk("fo_state", 32'(state), 0);
            chk("fo_ch_rstn", 32'(ch_rstn), 0);
            chk("fo_relock", 32'(relock_count), 1);
         end
         force_relock = (cyc == 42 || cyc == 44 || cyc == 80);
         if (cyc == 6) pll_locked = 1'b1;
         if (cyc == 40) pll_locked = 1'b0;
         if (cyc == 43) pll_locked = 1'b1;
         tick();
      end

      // ---- saturation, then reset in RELEASE ----
      do_reset();
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b1;
         n = 0;
         while (state != 3'd3 && n < 200) begin tick(); n++; end
         chk("sat_reach_release", 32'(state), 3);
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         n = 0;
         while (state != 3'd0 && n < 20) begin tick(); n++; end
         chk("sat_reach_reset", 32'(state), 0);
      end
      chk("sat_relock", 32'(relock_count), SATV);
      n = 0;
      while (state != 3'd3 && n < 200) begin tick(); n++; end
      for (int i = 0; i < 9; i++) tick();
      chk("mid_release_ch", 32'(ch_rstn), 3);
      resetn = 1'b0;
      tick();
      chk("rr_state", 32'(state), 0);
      chk("rr_pll_rst", 32'(pll_rst), 1);
      chk("rr_ch_rstn", 32'(ch_rstn), 0);
      chk("rr_ready", 32'(ready), 0);
      chk("rr_relock", 32'(relock_count), 0);
      chk("rr_timeout", 32'(timeout_count), 0);
      resetn = 1'b1;

      // ---- randomised run against the model ----
      for (int seg = 0; seg < 20; seg++) begin
         int thr;
         case ($urandom_range(0, 4))
            0: thr = 0;
            1: thr = 990;
            2: thr = 998;
            3: thr = 1000;
            default: thr = 700;
         endcase
         for (int c = 0; c < 200; c++) begin
            pll_locked   = ($urandom_range(0, 999) < thr);
            force_relock = ($urandom_range(0, 149) == 0);
            resetn       = ($urandom_range(0, 599) != 0);
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of downstream reset channels (1..16).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16, width of the pll_rst pulse in clkin cycles (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 250000, the maximum number of WAIT_LOCK cycles before the PLL is re-reset (>=2).
REQ-004 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, the number of consecutive locked cycles required before release (>=1).
REQ-005 SHALL have parameter STAGGER_CYCLES, default 8, the spacing between successive channel reset releases (>=1).
REQ-006 SHALL have parameter CNT_W, default 8, the width of the event counters.
REQ-007 clkin  in  1  25 MHz reference clock; sole clock of the block; all logic is clocked on its rising edge.
REQ-008 resetn  in  1  reset, synchronous, active-low.
REQ-009 pll_locked  in  1  LOCK from the EHXPLLL (PLLRST_ENA enabled); asynchronous to clkin.
REQ-010 force_relock  in  1  single-cycle request to re-reset the PLL.
REQ-011 pll_rst  out  1  drives the EHXPLLL RST pin; active-high.
REQ-012 ch_rstn  out  NUM_CH  per-domain reset, active-low.
REQ-013 ready  out  1  high when all channels are released and the PLL is locked.
REQ-014 state  out  3  0=PLL_RESET, 1=WAIT_LOCK, 2=STABLE, 3=RELEASE, 4=RUN.
REQ-015 relock_count  out  CNT_W  number of lock losses seen in RELEASE or RUN; saturating.
REQ-016 timeout_count  out  CNT_W  number of WAIT_LOCK timeouts; saturating.

Function
REQ-017 pll_locked SHALL pass through a 2-flop synchronizer to produce lock_s; all lock timing below refers to lock_s.
REQ-018 PLL_RESET SHALL hold pll_rst=1 for exactly PLL_RST_CYCLES cycles, then enter WAIT_LOCK; pll_rst SHALL be 0 in every other state.
REQ-019 WAIT_LOCK SHALL enter STABLE on the cycle after lock_s=1.
REQ-020 In WAIT_LOCK, if lock_s stays 0 for LOCK_TIMEOUT_CYCLES cycles, the block SHALL enter PLL_RESET and increment timeout_count.
REQ-021 STABLE SHALL enter RELEASE after LOCK_STABLE_CYCLES consecutive cycles with lock_s=1.
REQ-022 Any cycle in STABLE with lock_s=0 SHALL return the block to WAIT_LOCK, with the timeout counter restarted from 0; relock_count is unchanged.
REQ-023 In RELEASE, ch_rstn[0] SHALL go high on the first RELEASE cycle, and ch_rstn[k] SHALL go high exactly k*STAGGER_CYCLES cycles later.
REQ-024 A channel, once released, SHALL stay high until the next lock loss, force_relock or reset.
REQ-025 The block SHALL enter RUN on the cycle after ch_rstn[NUM_CH-1] rises; ready=1 exactly while in RUN.
REQ-026 lock_s=0 in RELEASE or RUN SHALL, on the next clock, drive all ch_rstn=0 and ready=0, enter PLL_RESET and increment relock_count.
REQ-027 force_relock=1 in any state other than PLL_RESET SHALL enter PLL_RESET on the next clock with all ch_rstn=0; no counter is incremented.
REQ-028 force_relock=1 while in PLL_RESET SHALL be ignored; the pulse is not restarted.
REQ-029 When lock loss and force_relock occur in the same cycle, the block SHALL make a single transition to PLL_RESET and increment relock_count by 1.
REQ-030 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 resetn=0 at a clkin edge SHALL set state=PLL_RESET, pll_rst=1, ch_rstn=0, ready=0, both counters=0, all internal counters=0 and the synchronizer flops=0.
REQ-033 After resetn is released, the PLL_RESET pulse SHALL run a full PLL_RST_CYCLES.
REQ-034 Reset asserted mid-sequence, in any state, SHALL take priority over all other inputs.

Verification (NUM_CH=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=10, STAGGER_CYCLES=8, CNT_W=8)
REQ-035 Bench SHALL check normal start: release resetn at cycle 0, pll_locked=1 from cycle 6 -> pll_rst high for cycles 0-3; ch_rstn[0], [1], [2] rise 8 cycles apart; ready rises 1 cycle after ch_rstn[2]; state sequence 0,1,2,3,4.
REQ-036 Bench SHALL check timeout: pll_locked held 0 -> pll_rst repulses every 4+20 cycles; timeout_count=3 after 3 periods; ready stays 0.
REQ-037 Bench SHALL check lock glitch in STABLE: drop pll_locked for 1 cycle after 5 locked cycles -> returns to WAIT_LOCK, ch_rstn stays 0, relock_count=0, then the full 10-cycle stable count restarts.
REQ-038 Bench SHALL check lock loss in RUN: drop pll_locked -> ch_rstn=3'b000 and ready=0 three cycles after the drop (2 synchronizer cycles + 1); state=0; relock_count=1; the full release sequence repeats on relock.
REQ-039 Bench SHALL check force_relock and lock loss in the same RUN cycle -> a single PLL_RESET entry, relock_count increments by exactly 1; force_relock pulsed during PLL_RESET -> pulse length unchanged.
REQ-040 Bench SHALL check saturation and reset: 300 lock losses -> relock_count=255; resetn=0 asserted in RELEASE -> all outputs at reset values on the next edge.
